mips_mc_ctrl: RTL
=================

// Module: mips_mc_ctrl
// PURPOSE
//  Multicycle control sequencer for the MIPS datapath. Owns the FSM that steps each instruction through
//  fetch/decode/execute/memory/writeback, and drives every datapath mux/strobe from a single shared
//  memory port. Stalls on a mem_ready handshake for both imem and dmem accesses. Sits beside the
//  datapath in mips top; opcode comes from the instruction register.
// PARAMETERS
//  CNT_W   32   width of retired-instruction counter
// PORTS
//  clock        in   1      single clock; all state updates on posedge
//  reset        in   1      synchronous, active-high
//  opcode       in   6      IR[31:26]; sampled in DECODE only
//  mem_ready    in   1      memory completes access this cycle
//  PCWrite      out  1      unconditional PC load
//  PCWriteCond  out  1      PC load when ALU zero (datapath ANDs with zero)
//  IorD         out  1      0=PC addresses memory, 1=ALUOut
//  MemRead      out  1      memory read request
//  MemWrite     out  1      memory write request
//  IRWrite      out  1      load instruction register
//  MemtoReg     out  1      1=MDR to regfile, 0=ALUOut
//  RegDst       out  1      1=rd, 0=rt
//  RegWrite     out  1      regfile write strobe
//  ALUSrcA      out  1      0=PC, 1=rs
//  ALUSrcB      out  2      00=rt 01=const 4 10=sign-ext imm 11=sign-ext imm<<2
//  ALUOp        out  2      00=add 01=sub 10=funct-decoded
//  PCSource     out  2      00=ALU result 01=ALUOut 10=jump target
//  inst_done    out  1      one-cycle pulse in final state of each instruction
//  illegal_op   out  1      sticky; unknown opcode decoded
//  retired      out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - States (4-bit): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 RWB=7 BRANCH=8 JUMP=9 ILLEGAL=10.
//  - reset=1 at posedge: state<=FETCH, retired<=0, illegal_op<=0. While reset high, all strobes
//    (PCWrite PCWriteCond MemRead MemWrite IRWrite RegWrite inst_done) forced 0; muxes 0.
//  - FETCH: MemRead=1 IorD=0 ALUSrcA=0 ALUSrcB=01 ALUOp=00 PCSource=00; IRWrite=PCWrite=mem_ready.
//    Stay while !mem_ready; ->DECODE when mem_ready.
//  - DECODE: ALUSrcA=0 ALUSrcB=11 ALUOp=00. opcode 100011/101011->MEMADR, 000000->EXEC,
//    000100->BRANCH, 000010->JUMP, other->ILLEGAL.
//  - MEMADR: ALUSrcA=1 ALUSrcB=10 ALUOp=00. LW->MEMRD, SW->MEMWR (opcode held stable by IR).
//  - MEMRD: MemRead=1 IorD=1; wait on mem_ready, then ->MEMWB.
//  - MEMWB: RegDst=0 MemtoReg=1 RegWrite=1 inst_done=1; ->FETCH.
//  - MEMWR: MemWrite=1 IorD=1; inst_done=mem_ready; wait, then ->FETCH.
//  - EXEC: ALUSrcA=1 ALUSrcB=00 ALUOp=10; ->RWB. RWB: RegDst=1 MemtoReg=0 RegWrite=1 inst_done=1; ->FETCH.
//  - BRANCH: ALUSrcA=1 ALUSrcB=00 ALUOp=01 PCWriteCond=1 PCSource=01 inst_done=1; ->FETCH.
//  - JUMP: PCWrite=1 PCSource=10 inst_done=1; ->FETCH.
//  - ILLEGAL: all strobes 0, illegal_op<=1, absorbing until reset.
//  - retired increments on every inst_done cycle; CNT_W-1..0 all ones wraps to 0.
//  - Latency with mem_ready always 1: LW 5, SW 4, R 4, BEQ 3, J 3 cycles.
//  - Reset mid-instruction: pending MemWrite/RegWrite never issued after the reset edge; restart at FETCH.
// CONFIGURATION
//  - MIPS_MC_ADDI_EN defined: opcode 001000 decodes to ADDI_EX=11 (ALUSrcA=1 ALUSrcB=10 ALUOp=00)
//    ->ADDI_WB=12 (RegDst=0 MemtoReg=0 RegWrite=1 inst_done=1) ->FETCH.
//  - Undefined: 001000 -> ILLEGAL; state codes 11/12 unreachable.
// STRUCTURE
//  - Shared header mips_defs.vh: opcode constants (R_TYPE LW SW BEQ J ADDI), funct codes, state
//    encodings, ALUSrcB/ALUOp/PCSource encodings; used by datapath, ALU control and this block.
//  - Sub-module mips_mc_outdec: purely combinational state+mem_ready -> control outputs; top holds
//    state register, next-state logic, retired counter, illegal_op flag, reset gating.
// TESTING
//  - Reset 2 cycles, mem_ready=1, opcode=100011 -> states 0,1,2,3,4; inst_done at cycle 5; retired=1.
//  - SW with mem_ready low 3 cycles in MEMWR -> MemWrite held 4 cycles, single inst_done, retired+1.
//  - FETCH with mem_ready=0 for 5 cycles -> IRWrite/PCWrite stay 0, state stays 0, MemRead=1 throughout.
//  - Sequence R,BEQ,J -> PCWriteCond=1 only in BRANCH with PCSource=01; PCWrite+PCSource=10 in JUMP; retired=3.
//  - opcode=111111 -> ILLEGAL, illegal_op=1, no strobes for 10 cycles; reset -> FETCH, illegal_op=0.
//  - CNT_W=4, 16 R-type instructions -> retired wraps 15->0; with MIPS_MC_ADDI_EN, 001000 -> states 11,12.

Source files
------------

// File: rtl/mips_mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer: opcodes, function codes,
// FSM state encodings, datapath mux encodings and the control bundle type.
package mips_mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXEC    = 4'd6,
        ST_RWB     = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9,
        ST_ILLEGAL = 4'd10,
        ST_ADDI_EX = 4'd11,
        ST_ADDI_WB = 4'd12
    } state_e;

    typedef enum logic [1:0] {
        SRCB_RT     = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } srcb_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pcsrc_e;

    typedef struct packed {
        logic   pcwrite;
        logic   pcwritecond;
        logic   iord;
        logic   memread;
        logic   memwrite;
        logic   irwrite;
        logic   memtoreg;
        logic   regdst;
        logic   regwrite;
        logic   alusrca;
        srcb_e  alusrcb;
        aluop_e aluop;
        pcsrc_e pcsource;
        logic   inst_done;
    } ctrl_t;

    // Loads and stores share the address-calculation state.
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control/handshake bundle between the multicycle sequencer (master) and the datapath (slave).
interface mips_mc_ctrl_if #(parameter int CNT_W = 32);

    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             inst_done;
    logic             illegal_op;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, inst_done, illegal_op, retired, state
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, inst_done, illegal_op, retired, state
    );

endinterface

// File: rtl/mips_mc_ctrl_outdec.sv
// Combinational decode of FSM state (plus mem_ready) into datapath control strobes and mux selects.
// ADDI states are decoded only when MIPS_MC_ADDI_EN is defined.
module mips_mc_ctrl_outdec
    import mips_mc_ctrl_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Per-state control decode; everything idles unless the state asks for it.
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.memread  = 1'b1;
                ctrl.alusrcb  = SRCB_FOUR;
                ctrl.irwrite  = mem_ready;
                ctrl.pcwrite  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alusrcb  = SRCB_IMM_SH;
            end
            ST_MEMADR: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = SRCB_IMM;
            end
            ST_MEMRD: begin
                ctrl.memread  = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.memtoreg  = 1'b1;
                ctrl.regwrite  = 1'b1;
                ctrl.inst_done = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.memwrite  = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.inst_done = mem_ready;
            end
            ST_EXEC: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = SRCB_RT;
                ctrl.aluop    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                ctrl.regdst    = 1'b1;
                ctrl.regwrite  = 1'b1;
                ctrl.inst_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = SRCB_RT;
                ctrl.aluop       = ALUOP_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = PCSRC_ALUOUT;
                ctrl.inst_done   = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pcwrite   = 1'b1;
                ctrl.pcsource  = PCSRC_JUMP;
                ctrl.inst_done = 1'b1;
            end
`ifdef MIPS_MC_ADDI_EN
            ST_ADDI_EX: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = SRCB_IMM;
            end
            ST_ADDI_WB: begin
                ctrl.regwrite  = 1'b1;
                ctrl.inst_done = 1'b1;
            end
`endif
            ST_ILLEGAL: begin
                ctrl = '0;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control sequencer: state register, next-state logic, retired counter and sticky
// illegal-opcode flag. Optional ADDI support is enabled by defining MIPS_MC_ADDI_EN.
module mips_mc_ctrl
    import mips_mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic           clock,
    input  logic           reset,
    mips_mc_ctrl_if.master bus
);

    state_e           state_r;
    state_e           next_state_s;
    logic [CNT_W-1:0] retired_r;
    logic             illegal_r;
    ctrl_t            ctrl_s;
    ctrl_t            ctrl_gated_s;

    mips_mc_ctrl_outdec u_outdec (
        .state     (state_r),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl_s)
    );

    // Next-state sequencing; memory states hold until mem_ready.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (bus.mem_ready) next_state_s = ST_DECODE;
                else               next_state_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (is_mem_op(bus.opcode)) begin
                    next_state_s = ST_MEMADR;
                end else begin
                    case (bus.opcode)
                        OP_RTYPE: next_state_s = ST_EXEC;
                        OP_BEQ:   next_state_s = ST_BRANCH;
                        OP_J:     next_state_s = ST_JUMP;
`ifdef MIPS_MC_ADDI_EN
                        OP_ADDI:  next_state_s = ST_ADDI_EX;
`endif
                        default:  next_state_s = ST_ILLEGAL;
                    endcase
                end
            end
            ST_MEMADR: begin
                if (bus.opcode == OP_LW) next_state_s = ST_MEMRD;
                else                     next_state_s = ST_MEMWR;
            end
            ST_MEMRD: begin
                if (bus.mem_ready) next_state_s = ST_MEMWB;
                else               next_state_s = ST_MEMRD;
            end
            ST_MEMWB:   next_state_s = ST_FETCH;
            ST_MEMWR: begin
                if (bus.mem_ready) next_state_s = ST_FETCH;
                else               next_state_s = ST_MEMWR;
            end
            ST_EXEC:    next_state_s = ST_RWB;
            ST_RWB:     next_state_s = ST_FETCH;
            ST_BRANCH:  next_state_s = ST_FETCH;
            ST_JUMP:    next_state_s = ST_FETCH;
            ST_ILLEGAL: next_state_s = ST_ILLEGAL;
`ifdef MIPS_MC_ADDI_EN
            ST_ADDI_EX: next_state_s = ST_ADDI_WB;
            ST_ADDI_WB: next_state_s = ST_FETCH;
`endif
            default:    next_state_s = ST_FETCH;
        endcase
    end

    // State, retired counter and sticky illegal flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_FETCH;
            retired_r <= '0;
            illegal_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (ctrl_s.inst_done) retired_r <= retired_r + CNT_W'(1);
            else                  retired_r <= retired_r;
            if (next_state_s == ST_ILLEGAL) illegal_r <= 1'b1;
            else                            illegal_r <= illegal_r;
        end
    end

    // Reset forces every strobe and mux select low so no write can leak out mid-instruction.
    always_comb begin
        ctrl_gated_s = '0;
        if (reset) ctrl_gated_s = '0;
        else       ctrl_gated_s = ctrl_s;
    end

    assign bus.PCWrite     = ctrl_gated_s.pcwrite;
    assign bus.PCWriteCond = ctrl_gated_s.pcwritecond;
    assign bus.IorD        = ctrl_gated_s.iord;
    assign bus.MemRead     = ctrl_gated_s.memread;
    assign bus.MemWrite    = ctrl_gated_s.memwrite;
    assign bus.IRWrite     = ctrl_gated_s.irwrite;
    assign bus.MemtoReg    = ctrl_gated_s.memtoreg;
    assign bus.RegDst      = ctrl_gated_s.regdst;
    assign bus.RegWrite    = ctrl_gated_s.regwrite;
    assign bus.ALUSrcA     = ctrl_gated_s.alusrca;
    assign bus.ALUSrcB     = ctrl_gated_s.alusrcb;
    assign bus.ALUOp       = ctrl_gated_s.aluop;
    assign bus.PCSource    = ctrl_gated_s.pcsource;
    assign bus.inst_done   = ctrl_gated_s.inst_done;
    assign bus.illegal_op  = illegal_r;
    assign bus.retired     = retired_r;
    assign bus.state       = state_r;

endmodule
